// File: rtl/lcd_video_out.sv
`default_nettype none
// ============================================================================
// Module   : lcd_video_out
// Desc     : Delays LCD timing by DLY cycles and aligns frame-buffer pixels to
//            the delayed de through a skid FIFO. The optional colour-bar source
//            is enabled by the macro LCD_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_video_out #(
    parameter int                DATA_W     = 16,
    parameter int                DLY        = 5,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] FILL_COLOR = 16'h0000,
    parameter int                H_RES      = 480
) (
    input  logic              video_clk,
    input  logic              rst_n,
    input  logic              i_vs,
    input  logic              i_hs,
    input  logic              i_de,
    input  logic              i_den,
    input  logic [DATA_W-1:0] i_data,
`ifdef LCD_TEST_PATTERN_EN
    input  logic              i_pattern_sel,
`endif
    output logic              o_lcd_vs,
    output logic              o_lcd_hs,
    output logic              o_lcd_de,
    output logic [4:0]        o_lcd_r,
    output logic [5:0]        o_lcd_g,
    output logic [4:0]        o_lcd_b,
    output logic [15:0]       o_underflow_cnt,
    output logic [15:0]       o_frame_cnt,
    output logic              o_ovf_err
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    generate
        if (DLY < 2 || DLY > 15 || FIFO_DEPTH < 4 || FIFO_DEPTH > 32 || H_RES < 8) begin : g_bad_cfg
            $error("lcd_video_out: illegal parameter set");
        end
    endgenerate

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    state_t r_state;

    // Stages 0..DLY-2 live here; the output registers form stage DLY-1.
    logic [DLY-2:0] r_vs_sr, r_hs_sr, r_de_sr;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [15:0]         r_pixel;

    logic w_vs_tap, w_hs_tap, w_de_tap, w_vs_rise, w_run;
    logic w_rd, w_wr, w_empty, w_full, w_bypass, w_push, w_pop, w_ovf, w_under;
    logic w_pat_on;
    logic [DATA_W-1:0] w_fifo_pix;
    logic [15:0]       w_pix;

    assign w_vs_tap  = r_vs_sr[DLY-2];
    assign w_hs_tap  = r_hs_sr[DLY-2];
    assign w_de_tap  = r_de_sr[DLY-2];
    assign w_vs_rise = w_vs_tap & ~o_lcd_vs;
    assign w_run     = (r_state == ST_RUN);

    assign w_rd     = w_run & w_de_tap;
    assign w_wr     = w_run & i_den;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_bypass = w_rd & w_wr & w_empty;
    assign w_push   = w_wr & ~w_bypass & (~w_full | w_rd) & ~w_vs_rise;
    assign w_pop    = w_rd & ~w_empty;
    assign w_ovf    = w_wr & w_full & ~w_rd;
    assign w_under  = w_rd & w_empty & ~w_wr & ~w_pat_on;

    assign w_fifo_pix = w_empty ? (w_wr ? i_data : FILL_COLOR) : r_mem[r_rd_ptr];

`ifdef LCD_TEST_PATTERN_EN
    localparam int c_bar_w = H_RES / 8;

    logic [10:0] r_pix_cnt;
    logic [10:0] w_bar_q;
    logic [2:0]  w_bar_idx;
    logic [15:0] w_bar_color;

    // Counter equals the index of the pixel being read; it rests at 0 outside de.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
        end else if (w_de_tap) begin
            r_pix_cnt <= r_pix_cnt + 11'd1;
        end else begin
            r_pix_cnt <= '0;
        end
    end

    assign w_bar_q   = r_pix_cnt / 11'(c_bar_w);
    assign w_bar_idx = (w_bar_q > 11'd7) ? 3'd7 : w_bar_q[2:0];

    always_comb begin
        w_bar_color = 16'h0000;
        case (w_bar_idx)
            3'd0:    w_bar_color = 16'hFFFF;
            3'd1:    w_bar_color = 16'hFFE0;
            3'd2:    w_bar_color = 16'h07FF;
            3'd3:    w_bar_color = 16'h07E0;
            3'd4:    w_bar_color = 16'hF81F;
            3'd5:    w_bar_color = 16'hF800;
            3'd6:    w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase
    end

    assign w_pat_on = i_pattern_sel;
    assign w_pix    = w_pat_on ? w_bar_color : w_fifo_pix[15:0];
`else
    assign w_pat_on = 1'b0;
    assign w_pix    = w_fifo_pix[15:0];
`endif

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            o_frame_cnt <= '0;
            o_ovf_err   <= 1'b0;
        end else if (w_vs_rise) begin
            r_state     <= ST_RUN;
            o_frame_cnt <= o_frame_cnt + 16'd1;
            o_ovf_err   <= 1'b0;
        end else if (w_ovf) begin
            o_ovf_err   <= 1'b1;
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_sr  <= '0;
            r_hs_sr  <= '0;
            r_de_sr  <= '0;
            o_lcd_vs <= 1'b0;
            o_lcd_hs <= 1'b0;
            o_lcd_de <= 1'b0;
        end else begin
            r_vs_sr[0] <= i_vs;
            r_hs_sr[0] <= i_hs;
            r_de_sr[0] <= i_de;
            for (int k = 1; k <= DLY - 2; k++) begin
                r_vs_sr[k] <= r_vs_sr[k-1];
                r_hs_sr[k] <= r_hs_sr[k-1];
                r_de_sr[k] <= r_de_sr[k-1];
            end
            o_lcd_vs <= w_vs_tap;
            o_lcd_hs <= w_hs_tap;
            o_lcd_de <= w_rd;
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_vs_rise) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge video_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel         <= '0;
            o_underflow_cnt <= '0;
        end else begin
            r_pixel <= w_rd ? w_pix : 16'h0000;
            if (w_under && o_underflow_cnt != 16'hFFFF) begin
                o_underflow_cnt <= o_underflow_cnt + 16'd1;
            end
        end
    end

    assign o_lcd_r = r_pixel[15:11];
    assign o_lcd_g = r_pixel[10:5];
    assign o_lcd_b = r_pixel[4:0];

endmodule
`default_nettype wire
